// File: rtl/flash_status_poller_pkg.sv
// Shared definitions for the flash status-register poller: SPI opcodes,
// status bit positions, request encoding and the sequencer state set.
package flash_status_poller_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] DUMMY   = 8'h00;

  localparam int STS_WIP = 0;
  localparam int STS_WEL = 1;

  typedef enum logic {
    POLL_WAIT_READY = 1'b0,
    POLL_WRITE_EN   = 1'b1
  } poll_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WREN_START,
    ST_WREN_TX,
    ST_WREN_WAIT,
    ST_RDSR_START,
    ST_RDSR_TX,
    ST_RDSR_WAIT,
    ST_CHECK,
    ST_GAP,
    ST_DONE
  } state_e;

  // A write-enable request also needs the latch to have taken (WEL set).
  function automatic logic status_pass(input poll_op_e op, input logic [7:0] sts);
    if (op == POLL_WRITE_EN) return sts[STS_WEL] && !sts[STS_WIP];
    return !sts[STS_WIP];
  endfunction

endpackage

// File: rtl/flash_status_poller.sv
// Drives the shared SPI controller through optional WREN followed by repeated
// RDSR transactions until the requested status condition holds or polls run out.
module flash_status_poller
  import flash_status_poller_pkg::*;
#(
  parameter int POLL_GAP  = 16,
  parameter int MAX_POLLS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_poll_start,
  input  logic        in_poll_op,
  output logic        out_poll_ready,
  output logic        out_poll_done,
  output logic        out_poll_error,
  output logic [7:0]  out_status,
  output logic        out_spi_start,
  output logic [15:0] out_spi_num_bytes,
  input  logic        in_spi_busy,
  input  logic        in_spi_done,
  output logic        out_spi_tx_valid,
  output logic [7:0]  out_spi_tx_data,
  input  logic        in_spi_tx_ready,
  input  logic        in_spi_rx_valid,
  input  logic [7:0]  in_spi_rx_data,
  output logic        out_spi_rx_ready
);

  localparam int PCNT_W = $clog2(MAX_POLLS + 1);
  localparam int GCNT_W = $clog2(POLL_GAP + 1);

  localparam logic [PCNT_W-1:0] POLL_LIMIT = PCNT_W'(MAX_POLLS);
  localparam logic [GCNT_W-1:0] GAP_LAST   = GCNT_W'(POLL_GAP - 1);

  state_e            state;
  poll_op_e          op_q;
  logic [PCNT_W-1:0] poll_cnt;
  logic [GCNT_W-1:0] gap_cnt;
  logic              tx_idx;
  logic [1:0]        rx_idx;

  logic              tx_fire;
  logic              rx_fire;
  logic              rx_complete;
  logic [PCNT_W-1:0] poll_cnt_inc;

  assign tx_fire      = out_spi_tx_valid && in_spi_tx_ready;
  assign rx_fire      = in_spi_rx_valid && out_spi_rx_ready;
  assign poll_cnt_inc = poll_cnt + 1'b1;
  // The last rx byte may land in the same cycle as the done pulse.
  assign rx_complete  = (rx_idx == 2'd2) || ((rx_idx == 2'd1) && rx_fire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= ST_IDLE;
      op_q              <= POLL_WAIT_READY;
      poll_cnt          <= '0;
      gap_cnt           <= '0;
      tx_idx            <= 1'b0;
      rx_idx            <= '0;
      out_status        <= '0;
      out_poll_ready    <= 1'b1;
      out_poll_done     <= 1'b0;
      out_poll_error    <= 1'b0;
      out_spi_start     <= 1'b0;
      out_spi_num_bytes <= '0;
      out_spi_tx_valid  <= 1'b0;
      out_spi_tx_data   <= '0;
      out_spi_rx_ready  <= 1'b0;
    end else begin
      out_poll_done <= 1'b0;

      // rx byte 0 is the echo clocked during the opcode; byte 1 is the status.
      if (rx_fire && (rx_idx != 2'd2)) begin
        if (rx_idx == 2'd1) out_status <= in_spi_rx_data;
        rx_idx <= rx_idx + 2'd1;
      end

      case (state)
        ST_IDLE: begin
          if (in_poll_start) begin
            op_q           <= poll_op_e'(in_poll_op);
            poll_cnt       <= '0;
            out_poll_ready <= 1'b0;
            out_poll_error <= 1'b0;
            if (in_poll_op) begin
              state             <= ST_WREN_START;
              out_spi_num_bytes <= 16'd1;
            end else begin
              state             <= ST_RDSR_START;
              out_spi_num_bytes <= 16'd2;
            end
          end
        end

        ST_WREN_START: begin
          if (!in_spi_busy) begin
            out_spi_start <= 1'b1;
            state         <= ST_WREN_TX;
          end
        end

        ST_WREN_TX: begin
          if (out_spi_start) begin
            out_spi_start    <= 1'b0;
            out_spi_tx_valid <= 1'b1;
            out_spi_tx_data  <= OP_WREN;
          end else if (tx_fire) begin
            out_spi_tx_valid <= 1'b0;
            state            <= ST_WREN_WAIT;
          end
        end

        ST_WREN_WAIT: begin
          if (in_spi_done) begin
            out_spi_num_bytes <= 16'd2;
            state             <= ST_RDSR_START;
          end
        end

        ST_RDSR_START: begin
          if (!in_spi_busy) begin
            out_spi_start    <= 1'b1;
            out_spi_rx_ready <= 1'b1;
            rx_idx           <= '0;
            tx_idx           <= 1'b0;
            state            <= ST_RDSR_TX;
          end
        end

        ST_RDSR_TX: begin
          if (out_spi_start) begin
            out_spi_start    <= 1'b0;
            out_spi_tx_valid <= 1'b1;
            out_spi_tx_data  <= OP_RDSR;
          end else if (tx_fire) begin
            if (!tx_idx) begin
              tx_idx          <= 1'b1;
              out_spi_tx_data <= DUMMY;
            end else begin
              out_spi_tx_valid <= 1'b0;
              state            <= ST_RDSR_WAIT;
            end
          end
        end

        ST_RDSR_WAIT: begin
          if (in_spi_done) begin
            out_spi_rx_ready <= 1'b0;
            if (rx_complete) begin
              state <= ST_CHECK;
            end else begin
              out_poll_done  <= 1'b1;
              out_poll_error <= 1'b1;
              state          <= ST_DONE;
            end
          end
        end

        ST_CHECK: begin
          if (status_pass(op_q, out_status)) begin
            out_poll_done  <= 1'b1;
            out_poll_error <= 1'b0;
            state          <= ST_DONE;
          end else begin
            poll_cnt <= poll_cnt_inc;
            if (poll_cnt_inc == POLL_LIMIT) begin
              out_poll_done  <= 1'b1;
              out_poll_error <= 1'b1;
              state          <= ST_DONE;
            end else begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_RDSR_START;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          out_poll_ready    <= 1'b1;
          out_spi_num_bytes <= '0;
          state             <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_status_poller.sv
// Bench for flash_status_poller: SPI controller model answering RDSR with a
// scripted status sequence, table of poll requests, plus busy and reset cases.
module tb_flash_status_poller;

  localparam int POLL_GAP  = 16;
  localparam int MAX_POLLS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_poll_start, in_poll_op;
  logic        out_poll_ready, out_poll_done, out_poll_error;
  logic [7:0]  out_status;
  logic        out_spi_start;
  logic [15:0] out_spi_num_bytes;
  logic        in_spi_busy, in_spi_done;
  logic        out_spi_tx_valid, in_spi_tx_ready;
  logic [7:0]  out_spi_tx_data;
  logic        in_spi_rx_valid, out_spi_rx_ready;
  logic [7:0]  in_spi_rx_data;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  flash_status_poller #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
    .clk(clk), .rst(rst),
    .in_poll_start(in_poll_start), .in_poll_op(in_poll_op),
    .out_poll_ready(out_poll_ready), .out_poll_done(out_poll_done),
    .out_poll_error(out_poll_error), .out_status(out_status),
    .out_spi_start(out_spi_start), .out_spi_num_bytes(out_spi_num_bytes),
    .in_spi_busy(in_spi_busy), .in_spi_done(in_spi_done),
    .out_spi_tx_valid(out_spi_tx_valid), .out_spi_tx_data(out_spi_tx_data),
    .in_spi_tx_ready(in_spi_tx_ready),
    .in_spi_rx_valid(in_spi_rx_valid), .in_spi_rx_data(in_spi_rx_data),
    .out_spi_rx_ready(out_spi_rx_ready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        op;
    logic [31:0] resp;       // status byte k at [8k+7:8k]; last one repeats
    int          n;
    int          short_at;   // RDSR index whose status byte is dropped, -1 none
    logic        exp_err;
    logic [7:0]  exp_status;
    int          exp_rdsr;
    int          exp_wren;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] status;
  } exp_t;

  exp_t sb[$];

  // SPI controller model state
  logic [31:0] cfg_resp;
  int          cfg_n, cfg_short;
  int          m_busy, m_n, m_cnt, busy_hold;
  logic [7:0]  m_tx0, m_tx1, rx_drop;
  logic [7:0]  rxq[$];
  logic        prev_start, prev_tx_valid, prev_rx_ready;
  logic [7:0]  prev_tx_data;
  logic [15:0] prev_nb;
  int          start_cnt, wren_cnt, rdsr_cnt, bad_cnt;
  int          last_done_cyc, gap_min, gap_max, first_start_cyc;
  logic        last_was_rdsr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] resp_byte(input int i);
    int k;
    k = (i < cfg_n) ? i : cfg_n - 1;
    return cfg_resp[8*k +: 8];
  endfunction

  // Handshakes are resolved from the previous negedge's output snapshot,
  // because that is what the DUT presented at the intervening posedge.
  initial begin
    in_spi_busy = 0; in_spi_done = 0; in_spi_tx_ready = 0;
    in_spi_rx_valid = 0; in_spi_rx_data = 0;
    m_busy = 0; m_n = 0; m_cnt = 0; busy_hold = 0;
    prev_start = 0; prev_tx_valid = 0; prev_rx_ready = 0; prev_tx_data = 0; prev_nb = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_busy = 0; m_cnt = 0; rxq.delete();
        in_spi_busy = 0; in_spi_done = 0; in_spi_tx_ready = 0;
        in_spi_rx_valid = 0; in_spi_rx_data = 0;
      end else begin
        in_spi_done = 0;
        if (prev_start) begin
          check("spi_start_while_busy", (in_spi_busy || m_busy != 0) ? 1 : 0, 0);
          start_cnt++;
          if (first_start_cyc < 0) first_start_cyc = cyc;
          if (last_was_rdsr) begin
            if (cyc - last_done_cyc < gap_min) gap_min = cyc - last_done_cyc;
            if (cyc - last_done_cyc > gap_max) gap_max = cyc - last_done_cyc;
          end
          m_busy = 1; m_n = int'(prev_nb); m_cnt = 0;
        end
        if (prev_tx_valid && in_spi_tx_ready) begin
          if (m_cnt == 0) m_tx0 = prev_tx_data; else m_tx1 = prev_tx_data;
          m_cnt++;
          if (m_n == 2 && !(m_cnt == 2 && rdsr_cnt == cfg_short))
            rxq.push_back((m_cnt == 1) ? 8'hA5 : resp_byte(rdsr_cnt));
        end
        if (prev_rx_ready && in_spi_rx_valid) rx_drop = rxq.pop_front();
        if (m_busy != 0 && m_cnt >= m_n && rxq.size() == 0) begin
          if (m_n == 1 && m_tx0 == 8'h06) begin
            wren_cnt++; last_was_rdsr = 0;
          end else if (m_n == 2 && m_tx0 == 8'h05 && m_tx1 == 8'h00) begin
            rdsr_cnt++; last_was_rdsr = 1;
          end else begin
            bad_cnt++; last_was_rdsr = 0;
          end
          in_spi_done = 1; m_busy = 0; last_done_cyc = cyc;
        end
        in_spi_tx_ready = (m_busy != 0) && (m_cnt < m_n);
        in_spi_rx_valid = (rxq.size() > 0);
        in_spi_rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
        in_spi_busy     = (m_busy != 0) || (busy_hold > 0);
        if (busy_hold > 0) busy_hold--;
      end
      prev_start    = out_spi_start;
      prev_tx_valid = out_spi_tx_valid;
      prev_tx_data  = out_spi_tx_data;
      prev_rx_ready = out_spi_rx_ready;
      prev_nb       = out_spi_num_bytes;
    end
  end

  task automatic setup(input vec_t v);
    cfg_resp = v.resp; cfg_n = v.n; cfg_short = v.short_at;
    start_cnt = 0; wren_cnt = 0; rdsr_cnt = 0; bad_cnt = 0;
    last_done_cyc = -1; last_was_rdsr = 0; gap_min = 1000000; gap_max = 0;
    first_start_cyc = -1;
  endtask

  task automatic issue(input vec_t v, input int hold, output int accept_cyc);
    int t;
    t = 0;
    while (!out_poll_ready && t < 100) begin @(negedge clk); t++; end
    check("ready_before_request", out_poll_ready, 1);
    sb.push_back('{v.exp_err, v.exp_status});
    accept_cyc = cyc;
    busy_hold = hold;
    in_poll_op = v.op;
    in_poll_start = 1;
    @(negedge clk);
    in_poll_start = 0;
    check("ready_low_after_accept", out_poll_ready, 0);
  endtask

  task automatic run_vec(input vec_t v, input int hold, input bit inject);
    int accept_cyc, done_cyc, extra;
    bit got;
    exp_t e;
    setup(v);
    issue(v, hold, accept_cyc);
    got = 0;
    for (int t = 0; t < 3000; t++) begin
      if (out_poll_done) begin got = 1; break; end
      in_poll_start = inject && (t == 20);
      in_poll_op    = ~v.op;
      @(negedge clk);
    end
    in_poll_start = 0;
    done_cyc = cyc;
    check("poll_done_seen", got, 1);
    if (got) begin
      if (sb.size() == 0) begin
        check("scoreboard_nonempty", 0, 1);
      end else begin
        e = sb.pop_front();
        check("poll_error", out_poll_error, e.err);
        check("out_status", out_status, e.status);
      end
      check("done_latency", done_cyc - last_done_cyc, (v.short_at < 0) ? 2 : 1);
    end
    check("rdsr_count", rdsr_cnt, v.exp_rdsr);
    check("wren_count", wren_cnt, v.exp_wren);
    check("bad_transactions", bad_cnt, 0);
    check("start_pulses", start_cnt, v.exp_rdsr + v.exp_wren);
    if (v.exp_rdsr > 1) begin
      check("gap_min", gap_min, POLL_GAP + 4);
      check("gap_max", gap_max, POLL_GAP + 4);
    end
    if (hold > 0) check("start_waits_for_busy", (first_start_cyc - accept_cyc >= 12) ? 1 : 0, 1);
    if (inject) begin
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (out_poll_done) extra++;
      end
      check("no_extra_done", extra, 0);
      check("no_extra_start", start_cnt, v.exp_rdsr + v.exp_wren);
      check("ready_back_idle", out_poll_ready, 1);
    end
  endtask

  vec_t vecs[9];
  vec_t hv;

  initial begin
    int acc;
    bit reached;
    in_poll_start = 0;
    in_poll_op = 0;
    repeat (3) @(negedge clk);
    check("reset_ready", out_poll_ready, 1);
    check("reset_done", out_poll_done, 0);
    check("reset_error", out_poll_error, 0);
    check("reset_status", out_status, 0);
    check("reset_spi_start", out_spi_start, 0);
    check("reset_num_bytes", out_spi_num_bytes, 0);
    check("reset_tx_valid", out_spi_tx_valid, 0);
    check("reset_rx_ready", out_spi_rx_ready, 0);
    rst = 1;
    repeat (2) @(negedge clk);

    //          op    resp          n  short err   status rdsr wren
    vecs[0] = '{1'b0, 32'h00000000, 1, -1, 1'b0, 8'h00, 1, 0};
    vecs[1] = '{1'b0, 32'h00010101, 4, -1, 1'b0, 8'h00, 4, 0};
    vecs[2] = '{1'b1, 32'h00000200, 2, -1, 1'b0, 8'h02, 2, 1};
    vecs[3] = '{1'b0, 32'h00000001, 1, -1, 1'b1, 8'h01, 4, 0};
    vecs[4] = '{1'b1, 32'h00020103, 3, -1, 1'b0, 8'h02, 3, 1};
    vecs[5] = '{1'b1, 32'h00000000, 1, -1, 1'b1, 8'h00, 4, 1};
    vecs[6] = '{1'b0, 32'h00000001, 2,  1, 1'b1, 8'h01, 2, 0};
    vecs[7] = '{1'b0, 32'h000000FE, 1, -1, 1'b0, 8'hFE, 1, 0};
    vecs[8] = '{1'b1, 32'h00000006, 1, -1, 1'b0, 8'h06, 1, 1};
    for (int i = 0; i < 9; i++) run_vec(vecs[i], 0, 1'b0);

    // Controller busy after accept, and a stray request mid-poll.
    hv = '{1'b0, 32'h00000001, 2, -1, 1'b0, 8'h00, 2, 0};
    run_vec(hv, 10, 1'b1);

    // Reset during the second RDSR's byte transfer.
    hv = '{1'b0, 32'h00000001, 1, -1, 1'b1, 8'h01, 4, 0};
    setup(hv);
    issue(hv, 0, acc);
    reached = 0;
    for (int t = 0; t < 500; t++) begin
      if (rdsr_cnt == 1 && out_spi_tx_valid && out_spi_tx_data == 8'h05) begin
        reached = 1; break;
      end
      @(negedge clk);
    end
    check("reached_rdsr_tx", reached, 1);
    check("status_before_reset", out_status, 8'h01);
    rst = 0;
    #1;
    sb.delete();
    check("midreset_ready", out_poll_ready, 1);
    check("midreset_done", out_poll_done, 0);
    check("midreset_error", out_poll_error, 0);
    check("midreset_status", out_status, 0);
    check("midreset_spi_start", out_spi_start, 0);
    check("midreset_num_bytes", out_spi_num_bytes, 0);
    check("midreset_tx_valid", out_spi_tx_valid, 0);
    check("midreset_rx_ready", out_spi_rx_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    hv = '{1'b0, 32'h00000000, 1, -1, 1'b0, 8'h00, 1, 0};
    run_vec(hv, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_status_poller.md
# flash_status_poller

Sequences the shared SPI controller to issue flash status-register transactions on behalf of the transaction FSM. On request it optionally sends Write Enable (0x06), then repeatedly issues Read Status Register (0x05) until the required status condition holds or a poll budget is exhausted. It sits between the transaction FSM (request side) and the SPI controller (byte-stream side), and owns the SPI controller only while a poll request is active.

## Interface
- POLL_GAP, 16: idle cycles between consecutive RDSR transactions (≥1)
- MAX_POLLS, 1024: RDSR attempts before timeout (≥1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_poll_start  in  1  request strobe; accepted only when out_poll_ready=1
- in_poll_op  in  1  0 = wait-ready (WIP=0), 1 = write-enable (WREN, then wait WEL=1 & WIP=0); sampled at accept
- out_poll_ready  out  1  high in IDLE only
- out_poll_done  out  1  one-cycle completion pulse
- out_poll_error  out  1  valid with out_poll_done; 1 = timeout or short transfer
- out_status  out  8  last complete status byte received
- out_spi_start  out  1  one-cycle transaction start pulse
- out_spi_num_bytes  out  16  byte count of current transaction, held stable until done
- in_spi_busy  in  1  SPI controller busy
- in_spi_done  in  1  SPI transaction complete pulse
- out_spi_tx_valid / out_spi_tx_data / in_spi_tx_ready  out/out/in  1/8/1  tx byte stream
- in_spi_rx_valid / in_spi_rx_data / out_spi_rx_ready  in/in/out  1/8/1  rx byte stream

## Operation
- States: IDLE, WREN_START, WREN_TX, WREN_WAIT, RDSR_START, RDSR_TX, RDSR_WAIT, CHECK, GAP, DONE.
- IDLE: start & ready → latch op, clear poll_cnt; op=1 → WREN_START, else RDSR_START.
- WREN_START: num_bytes=1; out_spi_start pulses in the first cycle with in_spi_busy=0, then → WREN_TX.
- WREN_TX: tx_valid=1, data=0x06; on valid&ready → WREN_WAIT. WREN_WAIT: on in_spi_done → RDSR_START.
- RDSR_START: num_bytes=2; start pulse as above; clear rx index → RDSR_TX.
- RDSR_TX: send 0x05, then 0x00 (dummy clock byte), each advancing on valid&ready; after second → RDSR_WAIT.
- rx_ready=1 in RDSR_TX and RDSR_WAIT, 0 elsewhere. rx byte 0 discarded; rx byte 1 loaded into out_status. rx may arrive during RDSR_TX.
- RDSR_WAIT: on in_spi_done → CHECK if 2 rx bytes received; otherwise DONE with error=1.
- CHECK: pass = (status[0]=0) for op=0; (status[1]=1 & status[0]=0) for op=1. Pass → DONE, error=0. Fail: poll_cnt+1; if new count = MAX_POLLS → DONE, error=1; else → GAP.
- GAP: count POLL_GAP cycles → RDSR_START. WREN is never reissued within a request.
- DONE: out_poll_done=1 for one cycle → IDLE.
- in_poll_start outside IDLE ignored. in_spi_done in IDLE/GAP/CHECK ignored.
- Reset (any time, including mid-transaction): state IDLE, all counters 0, out_status=0x00, all outputs 0 except out_poll_ready=1. An abandoned SPI transaction is not cleaned up.

## Timing
- Request accepted at edge N → *_START state at N+1; out_spi_start high at N+1 if in_spi_busy=0.
- out_spi_start is registered high for exactly one cycle per transaction; never while busy.
- tx_valid rises the cycle after the start pulse, holds data stable until ready.
- in_spi_done at cycle M in RDSR_WAIT → CHECK at M+1 → DONE at M+2 (pulse) or GAP; GAP lasts exactly POLL_GAP cycles before RDSR_START.
- Pass on first poll, wait-ready: done pulse 2 cycles after in_spi_done.
- poll_cnt width = clog2(MAX_POLLS+1); no wrap.

## Structure
- Shared package: opcode constants (OP_WREN=0x06, OP_RDSR=0x05, DUMMY=0x00), status bit indices (WIP=0, WEL=1), poll-op encoding, state enum.
- Single module; gap and poll counters inline, no sub-module.

## Test plan
- op=0, SPI returns status 0x00 on first RDSR → tx stream 0x05,0x00; num_bytes=2; done, error=0, out_status=0x00; exactly one start pulse.
- op=0, status 0x01 ×3 then 0x00 → 4 RDSR transactions, ≥16 idle cycles between each, done, error=0.
- op=1, status 0x00 then 0x02 → tx 0x06 (num_bytes=1), then two RDSRs; done, error=0, out_status=0x02.
- MAX_POLLS=4, status stuck 0x01 → exactly 4 RDSRs, done, error=1, out_status=0x01.
- in_spi_busy held high 10 cycles after accept → start pulse only after busy drops; in_poll_start during poll ignored.
- Reset asserted mid RDSR_TX → outputs to reset values immediately; ready=1; new request runs normally.
